// File: rtl/dzcpu_useq.sv
// dzcpu micro-sequencer: opcode latch, flow-index load and uop flow control.
// Optional memory-wait stall: define DZCPU_USEQ_MEMWAIT_EN.
module dzcpu_useq #(
  parameter int UPC_W    = 8,
  parameter int UOP_W    = 13,
  parameter int FLOW_LSB = 9
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMemData,
  input  logic [UPC_W-1:0] iUopFlowIdx,
  input  logic [UPC_W-1:0] iCbUopFlowIdx,
  input  logic [UOP_W-1:0] iUop,
  input  logic             iZero,
`ifdef DZCPU_USEQ_MEMWAIT_EN
  input  logic             iMemWait,
`endif
  output logic [7:0]       oMop,
  output logic             oCbMode,
  output logic [UPC_W-1:0] oUopAddr,
  output logic             oUopValid,
  output logic             oPcInc,
  output logic             oFlagUpdate,
  output logic             oEof
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] CBDEC  = 2'd2;
  localparam logic [1:0] EXEC   = 2'd3;

  localparam logic [3:0] F_OP      = 4'd0;
  localparam logic [3:0] F_INC     = 4'd1;
  localparam logic [3:0] F_EOF     = 4'd2;
  localparam logic [3:0] F_INC_EOF = 4'd3;
  localparam logic [3:0] F_EOF_FU  = 4'd4;
  localparam logic [3:0] F_INC_EFU = 4'd5;
  localparam logic [3:0] F_INC_EZ  = 4'd6;
  localparam logic [3:0] F_INC_ENZ = 4'd7;
  localparam logic [3:0] F_JCB     = 4'd8;
  localparam logic [3:0] F_UPD_FL  = 4'd9;

  logic [1:0]       state_q, state_d;
  logic [7:0]       mop_q, mop_d;
  logic             cb_q, cb_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic [UPC_W-1:0] upc_nx;
  logic [3:0]       flow;
  logic             stall;
  logic             valid, pc_inc, fl_upd, eof;

`ifdef DZCPU_USEQ_MEMWAIT_EN
  assign stall = iMemWait;
`else
  assign stall = 1'b0;
`endif

  assign flow   = iUop[UOP_W-1:FLOW_LSB];
  assign upc_nx = upc_q + UPC_W'(1);

  always_comb begin
    state_d = state_q;
    mop_d   = mop_q;
    cb_d    = cb_q;
    upc_d   = upc_q;
    valid   = 1'b0;
    pc_inc  = 1'b0;
    fl_upd  = 1'b0;
    eof     = 1'b0;
    if (!stall) begin
      unique case (state_q)
        FETCH: begin
          mop_d   = iMemData;
          cb_d    = 1'b0;
          state_d = DECODE;
        end
        DECODE: begin
          upc_d   = iUopFlowIdx;
          state_d = EXEC;
        end
        CBDEC: begin
          upc_d   = iCbUopFlowIdx;
          state_d = EXEC;
        end
        EXEC: begin
          valid = 1'b1;
          case (flow)
            F_INC: begin
              pc_inc = 1'b1;
              upc_d  = upc_nx;
            end
            F_EOF: begin
              eof     = 1'b1;
              state_d = FETCH;
            end
            F_INC_EOF: begin
              pc_inc  = 1'b1;
              eof     = 1'b1;
              state_d = FETCH;
            end
            F_EOF_FU: begin
              fl_upd  = 1'b1;
              eof     = 1'b1;
              state_d = FETCH;
            end
            F_INC_EFU: begin
              pc_inc  = 1'b1;
              fl_upd  = 1'b1;
              eof     = 1'b1;
              state_d = FETCH;
            end
            F_INC_EZ: begin
              pc_inc = 1'b1;
              if (iZero) begin
                eof     = 1'b1;
                state_d = FETCH;
              end else begin
                upc_d = upc_nx;
              end
            end
            F_INC_ENZ: begin
              pc_inc = 1'b1;
              if (!iZero) begin
                eof     = 1'b1;
                state_d = FETCH;
              end else begin
                upc_d = upc_nx;
              end
            end
            F_JCB: begin
              pc_inc  = 1'b1;
              mop_d   = iMemData;
              cb_d    = 1'b1;
              state_d = CBDEC;
            end
            F_UPD_FL: begin
              fl_upd = 1'b1;
              upc_d  = upc_nx;
            end
            // F_OP and reserved encodings just step
            default: upc_d = upc_nx;
          endcase
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= FETCH;
      mop_q   <= 8'h00;
      cb_q    <= 1'b0;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      mop_q   <= mop_d;
      cb_q    <= cb_d;
      upc_q   <= upc_d;
    end
  end

  assign oMop        = mop_q;
  assign oCbMode     = cb_q;
  assign oUopAddr    = upc_q;
  assign oUopValid   = valid;
  assign oPcInc      = pc_inc;
  assign oFlagUpdate = fl_upd;
  assign oEof        = eof;

endmodule
